// File: rtl/jar_pi_seq.sv
// Pi-digit display sequencer: fetches digits from an external registered ROM
// and presents each one for a programmable hold time, separated by blank gaps.
module jar_pi_seq #(
   parameter int unsigned HOLD_W  = 8,
   parameter int unsigned GAP_CYC = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic [8:0]        start_idx,
   input  logic [8:0]        run_len,
   input  logic [HOLD_W-1:0] hold,
   input  logic              loop_en,
   input  logic              pause,
   input  logic              abort,
   input  logic [3:0]        rom_hex,
   output logic [8:0]        rom_index,
   output logic [3:0]        digit_out,
   output logic              digit_valid,
   output logic              blank,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CAPTURE,
      S_SHOW,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

   state_t            state_q, state_d;
   logic [8:0]        start_q, start_d;
   logic [8:0]        len_q, len_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [8:0]        remaining_q, remaining_d;
   logic [HOLD_W-1:0] hcnt_q, hcnt_d;
   logic [3:0]        gcnt_q, gcnt_d;
   logic [8:0]        rom_index_q, rom_index_d;
   logic [3:0]        digit_q, digit_d;
   logic              valid_q, blank_q, busy_q, done_q;

   always_comb begin
      state_d     = state_q;
      start_d     = start_q;
      len_d       = len_q;
      hold_d      = hold_q;
      remaining_d = remaining_q;
      hcnt_d      = hcnt_q;
      gcnt_d      = gcnt_q;
      rom_index_d = rom_index_q;
      digit_d     = digit_q;

      // abort outranks every transition and leaves address/digit untouched
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (go) begin
                  start_d     = start_idx;
                  len_d       = run_len;
                  hold_d      = hold;
                  rom_index_d = start_idx;
                  remaining_d = run_len;
                  state_d     = S_FETCH;
               end
            end
            S_FETCH: state_d = S_CAPTURE;
            S_CAPTURE: begin
               digit_d = rom_hex;
               hcnt_d  = '0;
               state_d = S_SHOW;
            end
            S_SHOW: begin
               if (!pause) begin
                  if (hcnt_q == hold_q) begin
                     if (remaining_q != '0) begin
                        remaining_d = remaining_q - 9'd1;
                        rom_index_d = rom_index_q + 9'd1;
                        gcnt_d      = '0;
                        state_d     = S_GAP;
                     end else begin
                        state_d = S_DONE;
                     end
                  end else begin
                     hcnt_d = hcnt_q + 1'b1;
                  end
               end
            end
            S_GAP: begin
               if (gcnt_q == GAP_LAST) begin
                  state_d = S_FETCH;
               end else begin
                  gcnt_d = gcnt_q + 4'd1;
               end
            end
            S_DONE: begin
               if (loop_en) begin
                  rom_index_d = start_q;
                  remaining_d = len_q;
                  state_d     = S_FETCH;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // status flags are registered from the next state so they line up with state_q
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         start_q     <= '0;
         len_q       <= '0;
         hold_q      <= '0;
         remaining_q <= '0;
         hcnt_q      <= '0;
         gcnt_q      <= '0;
         rom_index_q <= '0;
         digit_q     <= '0;
         valid_q     <= 1'b0;
         blank_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         len_q       <= len_d;
         hold_q      <= hold_d;
         remaining_q <= remaining_d;
         hcnt_q      <= hcnt_d;
         gcnt_q      <= gcnt_d;
         rom_index_q <= rom_index_d;
         digit_q     <= digit_d;
         valid_q     <= (state_d == S_SHOW);
         blank_q     <= (state_d != S_SHOW);
         busy_q      <= (state_d != S_IDLE);
         done_q      <= (state_d == S_DONE);
      end
   end

   assign rom_index   = rom_index_q;
   assign digit_out   = digit_q;
   assign digit_valid = valid_q;
   assign blank       = blank_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_jar_pi_seq.sv
// Directed bench for jar_pi_seq with a 1-cycle-latency pi ROM model.
module tb_jar_pi_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       go = 1'b0;
   logic [8:0] start_idx = '0;
   logic [8:0] run_len = '0;
   logic [7:0] hold = '0;
   logic       loop_en = 1'b0;
   logic       pause = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] rom_hex = '0;
   logic [8:0] rom_index;
   logic [3:0] digit_out;
   logic       digit_valid, blank, busy, done;

   int unsigned nvec = 0;
   int unsigned nmis = 0;

   jar_pi_seq #(.HOLD_W(8), .GAP_CYC(1)) dut (
      .clk(clk), .reset(reset), .go(go), .start_idx(start_idx), .run_len(run_len),
      .hold(hold), .loop_en(loop_en), .pause(pause), .abort(abort), .rom_hex(rom_hex),
      .rom_index(rom_index), .digit_out(digit_out), .digit_valid(digit_valid),
      .blank(blank), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] rom_fn(input logic [8:0] a);
      case (a)
         9'd0: rom_fn = 4'd3;
         9'd1: rom_fn = 4'd1;
         9'd2: rom_fn = 4'd4;
         9'd3: rom_fn = 4'd1;
         9'd4: rom_fn = 4'd5;
         9'd5: rom_fn = 4'd9;
         default: rom_fn = a[3:0];
      endcase
   endfunction

   always @(posedge clk) rom_hex <= rom_fn(rom_index);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; abort = 1'b1; go = 1'b1;
      tick(); tick();
      nvec++; if (rom_index !== 9'd0) begin nmis++; $display("FAIL reset_rom_index got %0d want 0", rom_index); end
      nvec++; if (digit_out !== 4'd0) begin nmis++; $display("FAIL reset_digit got %0d want 0", digit_out); end
      nvec++; if (digit_valid !== 1'b0) begin nmis++; $display("FAIL reset_valid got %b want 0", digit_valid); end
      nvec++; if (blank !== 1'b1) begin nmis++; $display("FAIL reset_blank got %b want 1", blank); end
      nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL reset_busy got %b want 0", busy); end
      nvec++; if (done !== 1'b0) begin nmis++; $display("FAIL reset_done got %b want 0", done); end
      reset = 1'b0; abort = 1'b0; go = 1'b0;
      tick();
   endtask

   task automatic test_single_run();
      logic ev;
      logic [3:0] ed;
      start_idx = 9'd0; run_len = 9'd2; hold = 8'd3; loop_en = 1'b0; go = 1'b1;
      tick();
      go = 1'b0; start_idx = 9'h1FF; run_len = 9'd7; hold = 8'd0;
      for (int c = 1; c <= 23; c++) begin
         ev = (c >= 3 && c <= 6) || (c >= 10 && c <= 13) || (c >= 17 && c <= 20);
         ed = (c <= 6) ? 4'd3 : (c <= 13) ? 4'd1 : 4'd4;
         nvec++; if (digit_valid !== ev) begin nmis++; $display("FAIL single_valid c%0d got %b want %b", c, digit_valid, ev); end
         nvec++; if (blank !== !ev) begin nmis++; $display("FAIL single_blank c%0d got %b want %b", c, blank, !ev); end
         nvec++; if (done !== (c == 21)) begin nmis++; $display("FAIL single_done c%0d got %b want %b", c, done, (c == 21)); end
         nvec++; if (busy !== (c <= 21)) begin nmis++; $display("FAIL single_busy c%0d got %b want %b", c, busy, (c <= 21)); end
         if (ev) begin
            nvec++; if (digit_out !== ed) begin nmis++; $display("FAIL single_digit c%0d got %0d want %0d", c, digit_out, ed); end
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      logic [8:0] exp_idx [4];
      logic [3:0] exp_dig [4];
      int n = 0;
      logic prev = 1'b0;
      logic seen_done = 1'b0;
      exp_idx = '{9'd510, 9'd511, 9'd0, 9'd1};
      exp_dig = '{4'hE, 4'hF, 4'd3, 4'd1};
      start_idx = 9'd510; run_len = 9'd3; hold = 8'd0; go = 1'b1;
      tick();
      go = 1'b0;
      for (int c = 0; c < 200 && !seen_done; c++) begin
         if (digit_valid && !prev && n < 4) begin
            nvec++; if (rom_index !== exp_idx[n]) begin nmis++; $display("FAIL wrap_index d%0d got %0d want %0d", n, rom_index, exp_idx[n]); end
            nvec++; if (digit_out !== exp_dig[n]) begin nmis++; $display("FAIL wrap_digit d%0d got %0d want %0d", n, digit_out, exp_dig[n]); end
            n++;
         end
         if (done) seen_done = 1'b1;
         else begin prev = digit_valid; tick(); end
      end
      nvec++; if (!seen_done) begin nmis++; $display("FAIL wrap_timeout got no done want done"); end
      nvec++; if (n != 4) begin nmis++; $display("FAIL wrap_count got %0d want 4", n); end
      nvec++; if (rom_index !== 9'd1) begin nmis++; $display("FAIL wrap_final_index got %0d want 1", rom_index); end
      tick(); tick();
   endtask

   task automatic test_pause();
      int vcnt = 0;
      int dcyc = -1;
      start_idx = 9'd0; run_len = 9'd0; hold = 8'd3; go = 1'b1;
      tick();
      go = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         pause = (c >= 4 && c <= 8);
         if (digit_valid) vcnt++;
         if (done && dcyc < 0) dcyc = c;
         tick();
      end
      pause = 1'b0;
      nvec++; if (vcnt != 9) begin nmis++; $display("FAIL pause_valid_cycles got %0d want 9", vcnt); end
      nvec++; if (dcyc != 12) begin nmis++; $display("FAIL pause_done_cycle got %0d want 12", dcyc); end
   endtask

   task automatic test_loop();
      int n = 0;
      int dcnt = 0;
      logic prev = 1'b0;
      logic [3:0] ed;
      start_idx = 9'd2; run_len = 9'd1; hold = 8'd0; loop_en = 1'b1; go = 1'b1;
      tick();
      go = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         nvec++; if (busy !== 1'b1) begin nmis++; $display("FAIL loop_busy c%0d got %b want 1", c, busy); end
         if (digit_valid && !prev) begin
            ed = (n % 2 == 0) ? 4'd4 : 4'd1;
            nvec++; if (digit_out !== ed) begin nmis++; $display("FAIL loop_digit d%0d got %0d want %0d", n, digit_out, ed); end
            n++;
         end
         if (done) begin
            dcnt++;
            nvec++; if (n % 2 != 0 || n == 0) begin nmis++; $display("FAIL loop_done_pos c%0d got %0d digits want even", c, n); end
         end
         prev = digit_valid;
         tick();
      end
      nvec++; if (dcnt != 5) begin nmis++; $display("FAIL loop_done_count got %0d want 5", dcnt); end
      nvec++; if (n != 10) begin nmis++; $display("FAIL loop_digit_count got %0d want 10", n); end
      loop_en = 1'b0;
      for (int c = 0; c < 20 && busy; c++) tick();
      nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL loop_stop got busy=%b want 0", busy); end
   endtask

   task automatic test_abort();
      int c = 0;
      start_idx = 9'd4; run_len = 9'd2; hold = 8'd5; go = 1'b1;
      tick();
      go = 1'b0;
      while (!digit_valid && c < 20) begin tick(); c++; end
      nvec++; if (!digit_valid) begin nmis++; $display("FAIL abort_reach_show got valid=0 want 1"); end
      tick(); tick();
      abort = 1'b1; go = 1'b1;
      tick();
      abort = 1'b0; go = 1'b0;
      nvec++; if (digit_valid !== 1'b0) begin nmis++; $display("FAIL abort_valid got %b want 0", digit_valid); end
      nvec++; if (blank !== 1'b1) begin nmis++; $display("FAIL abort_blank got %b want 1", blank); end
      nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL abort_busy got %b want 0", busy); end
      nvec++; if (done !== 1'b0) begin nmis++; $display("FAIL abort_done got %b want 0", done); end
      nvec++; if (digit_out !== 4'd5) begin nmis++; $display("FAIL abort_digit_hold got %0d want 5", digit_out); end
      nvec++; if (rom_index !== 9'd4) begin nmis++; $display("FAIL abort_index_hold got %0d want 4", rom_index); end
      tick();
      nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL abort_stays_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_go_held();
      start_idx = 9'd3; run_len = 9'd0; hold = 8'd1; go = 1'b1;
      tick();
      for (int c = 1; c <= 5; c++) begin
         nvec++; if (digit_valid !== (c >= 3 && c <= 4)) begin nmis++; $display("FAIL goheld_valid c%0d got %b want %b", c, digit_valid, (c >= 3 && c <= 4)); end
         nvec++; if (done !== (c == 5)) begin nmis++; $display("FAIL goheld_done c%0d got %b want %b", c, done, (c == 5)); end
         nvec++; if (rom_index !== 9'd3) begin nmis++; $display("FAIL goheld_index c%0d got %0d want 3", c, rom_index); end
         if (c == 5) go = 1'b0;
         tick();
      end
      nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL goheld_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_gap();
      int c = 0;
      logic prev = 1'b0;
      logic found = 1'b0;
      start_idx = 9'd4; run_len = 9'd2; hold = 8'd0; go = 1'b1;
      tick();
      go = 1'b0;
      while (!found && c < 50) begin
         if (prev && !digit_valid) found = 1'b1;
         else begin prev = digit_valid; tick(); c++; end
      end
      nvec++; if (!found) begin nmis++; $display("FAIL rstgap_reach got no gap want gap"); end
      nvec++; if (busy !== 1'b1 || blank !== 1'b1) begin nmis++; $display("FAIL rstgap_gapflags got busy=%b blank=%b want 1 1", busy, blank); end
      nvec++; if (rom_index !== 9'd5) begin nmis++; $display("FAIL rstgap_gapindex got %0d want 5", rom_index); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      nvec++; if (rom_index !== 9'd0) begin nmis++; $display("FAIL rstgap_index got %0d want 0", rom_index); end
      nvec++; if (digit_out !== 4'd0) begin nmis++; $display("FAIL rstgap_digit got %0d want 0", digit_out); end
      nvec++; if (digit_valid !== 1'b0) begin nmis++; $display("FAIL rstgap_valid got %b want 0", digit_valid); end
      nvec++; if (blank !== 1'b1) begin nmis++; $display("FAIL rstgap_blank got %b want 1", blank); end
      nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL rstgap_busy got %b want 0", busy); end
      nvec++; if (done !== 1'b0) begin nmis++; $display("FAIL rstgap_done got %b want 0", done); end
      tick(); tick(); tick();
      nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL rstgap_stays_idle got busy=%b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single_run();
      test_wrap();
      test_pause();
      test_loop();
      test_abort();
      test_go_held();
      test_reset_gap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
